// File: rtl/ps2_key_rx_if.sv
// PS/2 keyboard pin and key-event bundle for ps2_key_rx.
// master drives the keyboard lines and consumes events; slave is the receiver.
interface ps2_key_rx_if;
  logic        ps2_kbd_clk;
  logic        ps2_kbd_data;
  logic [10:0] ps2_key;
  logic        rx_error;

  modport master (
    output ps2_kbd_clk,
    output ps2_kbd_data,
    input  ps2_key,
    input  rx_error
  );

  modport slave (
    input  ps2_kbd_clk,
    input  ps2_kbd_data,
    output ps2_key,
    output rx_error
  );
endinterface

// File: rtl/ps2_key_rx.sv
// PS/2 keyboard receiver: sync + clock filter, 11-bit deframer, E0/F0 prefix folding
// into the toggle-flagged key word. Define PS2_TYPEMATIC_FILTER_EN to drop autorepeat makes.
module ps2_key_rx #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 14318
) (
  input logic           clk_sys,
  input logic           reset,
  ps2_key_rx_if.slave   ps2
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DATA = 2'd1;
  localparam logic [1:0] S_PAR  = 2'd2;
  localparam logic [1:0] S_STOP = 2'd3;

  logic [1:0]    clk_sync_q, data_sync_q;
  logic          clk_filt_q, clk_filt_d;
  logic [7:0]    filt_cnt_q, filt_cnt_d;
  logic          fall, data_bit;

  logic [1:0]    state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          par_q, par_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;

  logic          byte_vld_q, byte_vld_d;
  logic [7:0]    byte_q, byte_d;
  logic          err_q, err_d;

  logic          ext_q, ext_d, brk_q, brk_d;
  logic [10:0]   key_q, key_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
  logic [511:0]  held_q, held_d;
`endif

  assign data_bit = data_sync_q[1];

  // The filtered clock only follows the line after FILTER_LEN matching samples.
  always_comb begin
    clk_filt_d = clk_filt_q;
    filt_cnt_d = '0;
    if (clk_sync_q[1] != clk_filt_q) begin
      if (filt_cnt_q == 8'(FILTER_LEN - 1)) clk_filt_d = clk_sync_q[1];
      else                                  filt_cnt_d = filt_cnt_q + 8'd1;
    end
  end

  assign fall = clk_filt_q & ~clk_filt_d;

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    byte_d     = byte_q;
    byte_vld_d = 1'b0;
    err_d      = 1'b0;
    if (state_q == S_IDLE || fall) to_cnt_d = '0;
    else                           to_cnt_d = to_cnt_q + 1'b1;

    if (state_q != S_IDLE && !fall && to_cnt_q == TW'(TIMEOUT_CYCLES - 1)) begin
      state_d  = S_IDLE;
      err_d    = 1'b1;
      to_cnt_d = '0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: if (!data_bit) begin
          state_d   = S_DATA;
          bit_cnt_d = 3'd0;
        end
        S_DATA: begin
          shift_d   = {data_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PAR;
        end
        S_PAR: begin
          par_d   = data_bit;
          state_d = S_STOP;
        end
        default: begin
          state_d = S_IDLE;
          if (data_bit && (^{shift_q, par_q})) begin
            byte_vld_d = 1'b1;
            byte_d     = shift_q;
          end else begin
            err_d = 1'b1;
          end
        end
      endcase
    end
  end

  // Byte decode stage: prefixes arm flags, real codes emit a toggled event.
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    key_d  = key_q;
`ifdef PS2_TYPEMATIC_FILTER_EN
    held_d = held_q;
`endif
    if (err_q) begin
      ext_d = 1'b0;
      brk_d = 1'b0;
    end else if (byte_vld_q) begin
      case (byte_q)
        8'hE0: ext_d = 1'b1;
        8'hF0: brk_d = 1'b1;
        8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
        default: begin
          ext_d = 1'b0;
          brk_d = 1'b0;
`ifdef PS2_TYPEMATIC_FILTER_EN
          if (brk_q) begin
            held_d[{ext_q, byte_q}] = 1'b0;
            key_d = {~key_q[10], 1'b0, ext_q, byte_q};
          end else if (!held_q[{ext_q, byte_q}]) begin
            held_d[{ext_q, byte_q}] = 1'b1;
            key_d = {~key_q[10], 1'b1, ext_q, byte_q};
          end
`else
          key_d = {~key_q[10], ~brk_q, ext_q, byte_q};
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      clk_sync_q  <= 2'b11;
      data_sync_q <= 2'b11;
      clk_filt_q  <= 1'b1;
      filt_cnt_q  <= '0;
      state_q     <= S_IDLE;
      to_cnt_q    <= '0;
      byte_vld_q  <= 1'b0;
      err_q       <= 1'b0;
      ext_q       <= 1'b0;
      brk_q       <= 1'b0;
      key_q       <= '0;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held_q      <= '0;
`endif
    end else begin
      clk_sync_q  <= {clk_sync_q[0], ps2.ps2_kbd_clk};
      data_sync_q <= {data_sync_q[0], ps2.ps2_kbd_data};
      clk_filt_q  <= clk_filt_d;
      filt_cnt_q  <= filt_cnt_d;
      state_q     <= state_d;
      to_cnt_q    <= to_cnt_d;
      byte_vld_q  <= byte_vld_d;
      err_q       <= err_d;
      ext_q       <= ext_d;
      brk_q       <= brk_d;
      key_q       <= key_d;
`ifdef PS2_TYPEMATIC_FILTER_EN
      held_q      <= held_d;
`endif
    end
  end

  always_ff @(posedge clk_sys) begin
    bit_cnt_q <= bit_cnt_d;
    shift_q   <= shift_d;
    par_q     <= par_d;
    byte_q    <= byte_d;
  end

  assign ps2.ps2_key  = key_q;
  assign ps2.rx_error = err_q;

endmodule

// File: tb/tb_ps2_key_rx.sv
// Bench for ps2_key_rx: directed and random PS/2 frames against a scan-code event model.
module tb_ps2_key_rx;
  localparam int FL = 8;
  localparam int TO = 2000;

  logic clk_sys = 1'b0;
  logic reset   = 1'b1;
  always #5 clk_sys = ~clk_sys;

  ps2_key_rx_if bus ();

  ps2_key_rx #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys (clk_sys),
    .reset   (reset),
    .ps2     (bus)
  );

  int nchk = 0, nerr = 0;
  int err_cnt = 0, tog_cnt = 0, coll_cnt = 0;
  logic prev10 = 1'b0;

  // Observed event stream: error-pulse cycles, toggles, and error/event collisions.
  always @(negedge clk_sys) begin
    if (reset) prev10 <= bus.ps2_key[10];
    else begin
      if (bus.rx_error) err_cnt <= err_cnt + 1;
      if (bus.ps2_key[10] !== prev10) begin
        tog_cnt <= tog_cnt + 1;
        if (bus.rx_error) coll_cnt <= coll_cnt + 1;
      end
      prev10 <= bus.ps2_key[10];
    end
  end

  // Reference model: key word, pending prefixes, held map, expected toggles/errors.
  logic [10:0] mkey = '0;
  bit mext = 0, mbrk = 0;
  bit mheld [512];
  int mtog = 0, merr = 0;

  int hp = 300;
  bit tim_chk = 0;
  logic [10:0] tim_old, tim_new;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk_sys);
    #1;
  endtask

  task automatic model_byte(input logic [7:0] b);
    bit emit;
    case (b)
      8'hE0: mext = 1;
      8'hF0: mbrk = 1;
      8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF: ;
      default: begin
        emit = 1;
`ifdef PS2_TYPEMATIC_FILTER_EN
        if (!mbrk && mheld[{mext, b}]) emit = 0;
        mheld[{mext, b}] = !mbrk;
`endif
        if (emit) begin
          mkey = {~mkey[10], ~mbrk, mext, b};
          mtog++;
        end
        mext = 0;
        mbrk = 0;
      end
    endcase
  endtask

  function automatic logic [10:0] mkframe(input logic [7:0] b, input bit badpar);
    return {1'b1, (~(^b)) ^ badpar, b, 1'b0};
  endfunction

  task automatic send_bits(input logic [10:0] fr, input int nbits, input int glitch);
    for (int i = 0; i < nbits; i++) begin
      bus.ps2_kbd_data = fr[i];
      if (i == glitch) begin
        cyc(hp / 2);
        bus.ps2_kbd_clk = 1'b0;
        cyc(3);
        bus.ps2_kbd_clk = 1'b1;
        cyc(hp - hp / 2 - 3);
      end else cyc(hp);
      bus.ps2_kbd_clk = 1'b0;
      if (tim_chk && i == 10) begin
        cyc(FL + 1);
        chk("lat_before", 32'(bus.ps2_key), 32'(tim_old));
        cyc(3);
        chk("lat_after", 32'(bus.ps2_key), 32'(tim_new));
        cyc(hp - FL - 4);
      end else cyc(hp);
      bus.ps2_kbd_clk = 1'b1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input bit badpar = 0, input int glitch = -1);
    tim_old = mkey;
    if (badpar) begin
      merr++;
      mext = 0;
      mbrk = 0;
    end else model_byte(b);
    tim_new = mkey;
    send_bits(mkframe(b, badpar), 11, glitch);
  endtask

  task automatic check_state(input string tag);
    cyc(FL + 8);
    @(negedge clk_sys);
    #1;
    chk({tag, "_key"}, 32'(bus.ps2_key), 32'(mkey));
    chk({tag, "_tog"}, 32'(tog_cnt), 32'(mtog));
    chk({tag, "_err"}, 32'(err_cnt), 32'(merr));
    chk({tag, "_coll"}, 32'(coll_cnt), 32'd0);
  endtask

  logic [7:0] disc [7] = '{8'hE1, 8'hAA, 8'hFA, 8'hFE, 8'hEE, 8'h00, 8'hFF};

  initial begin
    int e0, t0, r;
    logic [7:0] b;
    bus.ps2_kbd_clk  = 1'b1;
    bus.ps2_kbd_data = 1'b1;
    reset = 1'b1;
    cyc(4);
    chk("rst_key", 32'(bus.ps2_key), 32'd0);
    chk("rst_err", 32'(bus.rx_error), 32'd0);
    reset = 1'b0;
    cyc(20);

    tim_chk = 1;
    send_byte(8'h29);
    tim_chk = 0;
    check_state("make29");
    hp = 40;

    send_byte(8'hF0);
    check_state("f0_alone");
    send_byte(8'h29);
    check_state("brk29");

    send_byte(8'hE0); send_byte(8'h75);
    check_state("ext_make75");
    send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
    check_state("ext_brk75");

    send_byte(8'hF0);
    send_byte(8'h1C, 1);
    check_state("bad_parity");
    send_byte(8'h1C);
    check_state("after_parity");

    send_byte(8'hE0);
    e0 = err_cnt;
    send_bits(mkframe(8'h14, 0), 5, -1);
    for (int k = 0; k < TO + 200 && err_cnt == e0; k++) cyc(1);
    merr++;
    mext = 0;
    mbrk = 0;
    check_state("timeout");
    send_byte(8'h14);
    check_state("after_timeout");

    send_byte(8'h4B, 0, 4);
    check_state("glitch");

    for (int k = 0; k < 20; k++) begin
      bus.ps2_kbd_data = 1'($urandom);
      cyc(7);
    end
    bus.ps2_kbd_data = 1'b1;
    check_state("data_only");

    t0 = tog_cnt;
    send_byte(8'h29); send_byte(8'h29); send_byte(8'h29);
    send_byte(8'hF0); send_byte(8'h29);
    send_byte(8'h29);
    check_state("typematic");
`ifdef PS2_TYPEMATIC_FILTER_EN
    chk("typematic_toggles", 32'(tog_cnt - t0), 32'd3);
`else
    chk("typematic_toggles", 32'(tog_cnt - t0), 32'd5);
`endif

    for (int k = 0; k < 14; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else if (r == 2) b = disc[$urandom_range(0, 6)];
      else             b = 8'($urandom_range(1, 255));
      send_byte(b, $urandom_range(0, 7) == 0);
      check_state("random");
    end

    send_bits(mkframe(8'h33, 0), 6, -1);
    reset = 1'b1;
    cyc(3);
    chk("midrst_key", 32'(bus.ps2_key), 32'd0);
    chk("midrst_err", 32'(bus.rx_error), 32'd0);
    reset = 1'b0;
    mkey = '0;
    mext = 0;
    mbrk = 0;
    for (int k = 0; k < 512; k++) mheld[k] = 0;
    cyc(TO + 100);
    check_state("after_midrst");
    send_byte(8'h5A);
    check_state("post_rst_frame");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
